huff_canon_code_gen: RTL

//  Reader side of the bl_count register array: walks bit lengths 1..15 through its aux read port,

---
 rtl/huff_pkg.sv | 19 +
 rtl/huff_next_code_bank.sv | 63 ++++++
 rtl/huff_canon_code_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// Shared definitions for the canonical-Huffman code path: code/count widths
// and the generator FSM states used by the bl_count array and VLC writer.
package huff_pkg;

  localparam int MAX_BL = 15;
  localparam int CNT_W  = 9;
  localparam int CODE_W = MAX_BL;
  localparam int LEN_W  = 4;
  localparam int ACC_W  = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPT,
    ST_READY,
    ST_ERR
  } gen_state_e;

endpackage

// File: rtl/huff_next_code_bank.sv
// Per-length table of the next canonical code and the number of codes still
// available at that length. Generation fills one entry per CAPT cycle; the
// assignment port reads an entry combinationally and, when told to take a code,
// advances that entry at the same clock edge, so back-to-back requests on one
// length see the updated value on the following cycle.
module huff_next_code_bank
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [CODE_W-1:0] wr_code,
  input  logic [CNT_W-1:0]  wr_rem,
  input  logic [LEN_W-1:0]  rmw_len,
  input  logic              rmw_take,
  output logic [CODE_W-1:0] rmw_code,
  output logic [CNT_W-1:0]  rmw_rem
);

  // Entry i holds length i+1; length 0 has no storage and reads as empty.
  logic [CODE_W-1:0] code_tab [MAX_BL];
  logic [CNT_W-1:0]  rem_tab  [MAX_BL];

  // Table storage: clear on a new generation, fill during CAPT, advance on a taken code.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < MAX_BL; i++) begin
        code_tab[i] <= '0;
        rem_tab[i]  <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < MAX_BL; i++) begin
        code_tab[i] <= '0;
        rem_tab[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_BL; i++) begin
        if (wr_en && (wr_len == LEN_W'(i + 1))) begin
          code_tab[i] <= wr_code;
          rem_tab[i]  <= wr_rem;
        end else if (rmw_take && (rmw_len == LEN_W'(i + 1))) begin
          code_tab[i] <= code_tab[i] + CODE_W'(1);
          rem_tab[i]  <= rem_tab[i] - CNT_W'(1);
        end
      end
    end
  end

  // Assignment-side read mux; an unmatched length (0) reads as an exhausted entry.
  always_comb begin
    rmw_code = '0;
    rmw_rem  = '0;
    for (int i = 0; i < MAX_BL; i++) begin
      if (rmw_len == LEN_W'(i + 1)) begin
        rmw_code = code_tab[i];
        rmw_rem  = rem_tab[i];
      end
    end
  end

endmodule

// File: rtl/huff_canon_code_gen.sv
// Canonical-Huffman code generator. Walks bl_count[1..15] through the array's
// aux read port, building next_code[len] and a per-length remaining count while
// running a prefix Kraft check, then hands out canonical codes by length.
module huff_canon_code_gen
  import huff_pkg::*;
(
  input  logic              clk,
  input  logic              rstN,
  input  logic              start,
  output logic [3:0]        bl_addr,
  input  logic [CNT_W-1:0]  bl_data,
  input  logic              bl_busy,
  output logic              gen_done,
  output logic              ready,
  output logic              err_oversub,
  input  logic              code_req,
  input  logic [3:0]        code_len,
  output logic              code_vld,
  output logic [CODE_W-1:0] code,
  output logic              code_err
);

  gen_state_e        state;
  gen_state_e        state_nxt;

  // bit_len is the length being walked; acc is the first code at that length
  // scaled to bit_len bits, so sum > 2^bit_len means the prefix overflows Kraft.
  logic [LEN_W-1:0]  bit_len;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  limit;
  logic              oversub;
  logic              last_len;

  logic              gen_start;
  logic              tab_wr;
  logic              accept;
  logic              code_ok;
  logic [CODE_W-1:0] bank_code;
  logic [CNT_W-1:0]  bank_rem;

  // Kraft arithmetic for the length currently being captured.
  always_comb begin
    sum      = acc + ACC_W'(bl_data);
    limit    = ACC_W'(1) << bit_len;
    oversub  = sum > limit;
    last_len = bit_len == LEN_W'(MAX_BL);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: busy stalls ISSUE, an overflowing prefix aborts to ERR.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: if (!bl_busy) state_nxt = ST_CAPT;
      ST_CAPT: begin
        if (oversub) begin
          state_nxt = ST_ERR;
        end else if (last_len) begin
          state_nxt = ST_READY;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_READY: if (start) state_nxt = ST_ISSUE;
      ST_ERR:   if (start) state_nxt = ST_ISSUE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and control strobes; a start in READY wins over a same-cycle request.
  always_comb begin
    bl_addr     = '0;
    ready       = 1'b0;
    err_oversub = 1'b0;
    gen_start   = 1'b0;
    tab_wr      = 1'b0;
    accept      = 1'b0;
    code_ok     = 1'b0;
    case (state)
      ST_IDLE:  gen_start = start;
      ST_ISSUE: bl_addr = bit_len;
      ST_CAPT:  tab_wr = 1'b1;
      ST_READY: begin
        ready     = 1'b1;
        gen_start = start;
        accept    = code_req && !start;
        code_ok   = accept && (code_len != 4'd0) && (bank_rem != '0);
      end
      ST_ERR: begin
        err_oversub = 1'b1;
        gen_start   = start;
      end
      default: ;
    endcase
  end

  // Generation walk state, completion pulse and registered assignment response.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bit_len  <= '0;
      acc      <= '0;
      gen_done <= 1'b0;
      code_vld <= 1'b0;
      code     <= '0;
      code_err <= 1'b0;
    end else begin
      gen_done <= tab_wr && !oversub && last_len;
      if (gen_start) begin
        bit_len <= LEN_W'(1);
        acc     <= '0;
      end else if (tab_wr && !oversub) begin
        bit_len <= bit_len + LEN_W'(1);
        acc     <= {sum[ACC_W-2:0], 1'b0};
      end
      code_vld <= accept;
      code_err <= accept && !code_ok;
      code     <= code_ok ? bank_code : '0;
    end
  end

  huff_next_code_bank u_bank (
    .clk      (clk),
    .rstN     (rstN),
    .clear    (gen_start),
    .wr_en    (tab_wr),
    .wr_len   (bit_len),
    .wr_code  (acc[CODE_W-1:0]),
    .wr_rem   (bl_data),
    .rmw_len  (code_len),
    .rmw_take (code_ok),
    .rmw_code (bank_code),
    .rmw_rem  (bank_rem)
  );

endmodule
